// File: rtl/flappy_pkg.sv
// Shared types and playfield constants for the flappy-bird game blocks.
// Pure declarations: no logic, no latency.
// Not applicable to flow control; consumers use these types directly.
package flappy_pkg;

    localparam int Y_W    = 8;    // width of a vertical coordinate
    localparam int Y_MAX  = 239;  // last visible row (floor)
    localparam int BIRD_H = 8;    // bird sprite height in rows

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        HIT
    } state_t;

    // Vertical velocity in rows per tick, range -8..+8.
    typedef logic signed [4:0] vel_t;

endpackage

// File: rtl/rise_edge.sv
// One-cycle rising-edge detector for button levels.
// Latency: combinational pulse in the cycle the level first reads high.
// No backpressure; the pulse is lost if nobody samples it that cycle.
//   clk   : system clock
//   reset : synchronous active-high, clears the history bit
//   in    : level input (already debounced)
//   pulse : high for the single cycle where in=1 and the delayed copy is 0
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_d <= 1'b0;
        end else begin
            in_d <= in;
        end
    end

    assign pulse = in & ~in_d;

endmodule

// File: rtl/bird_physics.sv
// Per-frame bird engine: gravity/flap integration, ceiling/floor/pipe hits, score.
// Latency: bird_y/vel update on the edge ending the tick cycle; hits and score 1 cycle.
// No backpressure; the game manager gates progress with game_enable/game_reset.
//   clk, reset           : system clock, synchronous active-high reset
//   game_reset           : manager in ready state, restores reset values
//   game_enable          : manager in playing state
//   tick, flap           : frame strobe, debounced flap level
//   pipe_overlap, gap_*  : current pipe column and its open rows
//   pipe_passed          : pulse when a pipe clears the bird
//   bird_y, collision    : bird top row, sticky hit flag
//   score                : pipes passed, saturating at 255
module bird_physics
    import flappy_pkg::*;
#(
    parameter int Y_START  = 120,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -6,
    parameter int V_MAX    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           game_reset,
    input  logic           game_enable,
    input  logic           tick,
    input  logic           flap,
    input  logic           pipe_overlap,
    input  logic [Y_W-1:0] gap_top,
    input  logic [Y_W-1:0] gap_bot,
    input  logic           pipe_passed,
    output logic [Y_W-1:0] bird_y,
    output logic           collision,
    output logic [7:0]     score
);

    // Lowest legal top row: the sprite's bottom row sits on Y_MAX.
    localparam logic signed [Y_W+1:0] Y_LOW    = (Y_W+2)'(Y_MAX - BIRD_H + 1);
    localparam logic [Y_W-1:0]        Y_RST    = Y_W'(Y_START);
    localparam logic signed [5:0]     GRAV6    = 6'(GRAVITY);
    localparam logic signed [5:0]     VMAX6    = 6'(V_MAX);
    localparam vel_t                  FLAP_V   = vel_t'(FLAP_VEL);
    localparam logic [Y_W:0]          BOT_OFS  = (Y_W+1)'(BIRD_H - 1);

    state_t         state, state_nx;
    vel_t           vel, vel_nx;
    logic [Y_W-1:0] y_nx;
    logic           coll_nx;
    logic [7:0]     score_nx;
    logic           latch, latch_nx;
    logic           flap_pulse;

    // The edge history is part of the game state, so a restart clears it too.
    rise_edge u_flap_edge (
        .clk   (clk),
        .reset (reset | game_reset),
        .in    (flap),
        .pulse (flap_pulse)
    );

    // Velocity for this tick: a pending or same-cycle flap overrides gravity.
    logic signed [5:0]     vel_ext, vel_inc;
    vel_t                  vel_tick;
    logic signed [Y_W+1:0] y_ext, v_ext, y_sum;
    logic                  hit_top, hit_floor;
    logic [Y_W-1:0]        y_clamp;
    logic [Y_W:0]          bird_bot;
    logic                  pipe_hit;

    always_comb begin
        vel_ext  = {vel[4], vel};
        vel_inc  = vel_ext + GRAV6;
        if (latch || flap_pulse) begin
            vel_tick = FLAP_V;
        end else if (vel_inc > VMAX6) begin
            vel_tick = VMAX6[4:0];
        end else begin
            vel_tick = vel_inc[4:0];
        end

        // Two guard bits keep both the negative and the past-floor overshoot visible.
        y_ext     = {2'b00, bird_y};
        v_ext     = {{(Y_W-3){vel_tick[4]}}, vel_tick};
        y_sum     = y_ext + v_ext;
        hit_top   = (y_sum < 0);
        hit_floor = (y_sum > Y_LOW);
        if (hit_top) begin
            y_clamp = '0;
        end else if (hit_floor) begin
            y_clamp = Y_LOW[Y_W-1:0];
        end else begin
            y_clamp = y_sum[Y_W-1:0];
        end

        // Pipe test uses the registered position, one bit wider for the bottom row.
        bird_bot = {1'b0, bird_y} + BOT_OFS;
        pipe_hit = pipe_overlap && ((bird_y < gap_top) || (bird_bot > {1'b0, gap_bot}));
    end

    always_comb begin
        state_nx = state;
        y_nx     = bird_y;
        vel_nx   = vel;
        coll_nx  = collision;
        score_nx = score;
        latch_nx = latch;

        if (game_reset) begin
            state_nx = IDLE;
            y_nx     = Y_RST;
            vel_nx   = '0;
            coll_nx  = 1'b0;
            score_nx = '0;
            latch_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (game_enable) begin
                        state_nx = FLY;
                    end
                end
                FLY: begin
                    // With game_enable low the manager is in its done state: hold.
                    if (game_enable) begin
                        if (tick) begin
                            vel_nx   = vel_tick;
                            y_nx     = y_clamp;
                            latch_nx = 1'b0;
                        end else if (flap_pulse) begin
                            latch_nx = 1'b1;
                        end

                        // A hit in the same cycle as a pass suppresses the increment.
                        if (pipe_hit || (tick && (hit_top || hit_floor))) begin
                            coll_nx  = 1'b1;
                            state_nx = HIT;
                        end else if (pipe_passed && (score != 8'hFF)) begin
                            score_nx = score + 8'd1;
                        end
                    end
                end
                HIT: begin
                    // Frozen until the manager restarts the game.
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bird_y    <= Y_RST;
            vel       <= '0;
            collision <= 1'b0;
            score     <= '0;
            latch     <= 1'b0;
        end else begin
            state     <= state_nx;
            bird_y    <= y_nx;
            vel       <= vel_nx;
            collision <= coll_nx;
            score     <= score_nx;
            latch     <= latch_nx;
        end
    end

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: stimulus queues expectations tagged with the
// cycle they apply to; a negedge monitor pops and compares them.
module tb_bird_physics;

    logic       clk;
    logic       reset;
    logic       game_reset;
    logic       game_enable;
    logic       tick;
    logic       flap;
    logic       pipe_overlap;
    logic [7:0] gap_top;
    logic [7:0] gap_bot;
    logic       pipe_passed;
    logic [7:0] bird_y;
    logic       collision;
    logic [7:0] score;

    bird_physics dut (
        .clk          (clk),
        .reset        (reset),
        .game_reset   (game_reset),
        .game_enable  (game_enable),
        .tick         (tick),
        .flap         (flap),
        .pipe_overlap (pipe_overlap),
        .gap_top      (gap_top),
        .gap_bot      (gap_bot),
        .pipe_passed  (pipe_passed),
        .bird_y       (bird_y),
        .collision    (collision),
        .score        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs; a negative field means "don't care".
    typedef struct {
        int    cyc;
        int    y;
        int    c;
        int    s;
        string nm;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every entry due at this cycle's negedge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cycle %0d, now %0d", e.nm, e.cyc, cyc);
            end else begin
                if (e.y >= 0) begin
                    checks++;
                    if (int'(bird_y) != e.y) begin
                        errors++;
                        $display("FAIL %s bird_y got %0d expected %0d", e.nm, bird_y, e.y);
                    end
                end
                if (e.c >= 0) begin
                    checks++;
                    if (int'(collision) != e.c) begin
                        errors++;
                        $display("FAIL %s collision got %0d expected %0d", e.nm, collision, e.c);
                    end
                end
                if (e.s >= 0) begin
                    checks++;
                    if (int'(score) != e.s) begin
                        errors++;
                        $display("FAIL %s score got %0d expected %0d", e.nm, score, e.s);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k=0: value visible in the current cycle; k=1: after the next edge.
    task automatic expect_at(input int k, input int y, input int c, input int s, input string nm);
        exp_t e;
        e.cyc = cyc + k;
        e.y   = y;
        e.c   = c;
        e.s   = s;
        e.nm  = nm;
        q.push_back(e);
    endtask

    // One tick cycle followed by one quiet cycle; bird_y must move exactly one cycle later.
    task automatic do_tick(input int y_pre, input int y_post, input int c_post, input string nm);
        tick = 1'b1;
        expect_at(0, y_pre, -1, -1, {nm, "_pre"});
        expect_at(1, y_post, c_post, -1, nm);
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic restart(input string nm);
        game_reset = 1'b1;
        step();
        game_reset = 1'b0;
        expect_at(0, 120, 0, 0, nm);
        step();
    endtask

    // Free fall from 120: velocity ramps 1..8, then the floor clamps at 232.
    int fall_y [18] = '{121, 123, 126, 130, 135, 141, 148, 156, 164,
                        172, 180, 188, 196, 204, 212, 220, 228, 232};

    initial begin
        reset        = 1'b1;
        game_reset   = 1'b1;
        game_enable  = 1'b0;
        tick         = 1'b0;
        flap         = 1'b0;
        pipe_overlap = 1'b0;
        gap_top      = 8'd0;
        gap_bot      = 8'd0;
        pipe_passed  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        expect_at(0, 120, 0, 0, "reset_state");

        // IDLE ignores ticks, flaps and passes while game_reset is high.
        tick        = 1'b1;
        flap        = 1'b1;
        pipe_passed = 1'b1;
        expect_at(1, 120, 0, 0, "idle_ignore");
        step();
        tick        = 1'b0;
        flap        = 1'b0;
        pipe_passed = 1'b0;
        step();

        // Free fall: 121, 123, 126, 130.
        game_reset  = 1'b0;
        game_enable = 1'b1;
        step();
        do_tick(120, 121, 0, "fall1");
        do_tick(121, 123, 0, "fall2");
        do_tick(123, 126, 0, "fall3");
        do_tick(126, 130, 0, "fall4");

        // Flap: two edges before one tick count once; latch clears on that tick.
        flap = 1'b1; step();
        flap = 1'b0; step();
        flap = 1'b1; step();
        do_tick(130, 124, 0, "flap_tick");
        do_tick(124, 119, 0, "flap_after");
        flap = 1'b0;
        step();

        // Score: three passes.
        for (int i = 0; i < 3; i++) begin
            pipe_passed = 1'b1;
            expect_at(1, -1, 0, i + 1, "score_inc");
            step();
            pipe_passed = 1'b0;
            step();
        end

        // Pass coincident with a pipe hit: collision wins.
        pipe_overlap = 1'b1;
        gap_top      = 8'd0;
        gap_bot      = 8'd0;
        pipe_passed  = 1'b1;
        expect_at(0, -1, 0, 3, "coinc_pre");
        expect_at(1, 119, 1, 3, "coinc_hit");
        step();
        pipe_overlap = 1'b0;
        pipe_passed  = 1'b0;
        step();

        // HIT freezes position and score.
        pipe_passed = 1'b1;
        do_tick(119, 119, 1, "hit_freeze");
        expect_at(0, -1, 1, 3, "hit_score");
        pipe_passed = 1'b0;
        step();

        // Restart from HIT; a flap edge during game_reset is not latched.
        game_reset = 1'b1;
        flap       = 1'b1;
        step();
        game_reset = 1'b0;
        expect_at(0, 120, 0, 0, "restart");
        step();
        step();
        do_tick(120, 121, 0, "restart_tick");
        flap = 1'b0;

        // Pipe: bird rows 121..128 inside gap 110..128, then gap_bot 127 hits.
        pipe_overlap = 1'b1;
        gap_top      = 8'd110;
        gap_bot      = 8'd128;
        for (int i = 0; i < 3; i++) begin
            expect_at(1, -1, 0, -1, "gap_clear");
            step();
        end
        gap_top = 8'd121;
        expect_at(1, -1, 0, -1, "gap_top_edge");
        step();
        gap_top = 8'd110;
        gap_bot = 8'd127;
        expect_at(0, 121, 0, -1, "pipe_pre");
        expect_at(1, 121, 1, -1, "pipe_hit");
        step();
        pipe_overlap = 1'b0;
        step();

        // Floor: fall until 228 at terminal velocity, next tick clamps to 232.
        restart("restart_floor");
        for (int i = 0; i < 18; i++) begin
            do_tick((i == 0) ? 120 : fall_y[i-1], fall_y[i], (i == 17) ? 1 : 0, "floor_fall");
        end
        do_tick(232, 232, 1, "floor_hold");
        do_tick(232, 232, 1, "floor_hold2");

        // Saturation at 255.
        restart("restart_sat");
        for (int i = 0; i < 255; i++) begin
            pipe_passed = 1'b1;
            step();
            pipe_passed = 1'b0;
            step();
        end
        expect_at(0, -1, 0, 255, "sat_255");
        pipe_passed = 1'b1;
        expect_at(1, -1, 0, 255, "sat_hold");
        step();
        pipe_passed = 1'b0;
        step();

        // Done state (enable and reset both low): everything holds.
        game_enable = 1'b0;
        tick        = 1'b1;
        pipe_passed = 1'b1;
        expect_at(1, 120, 0, 255, "done_hold");
        step();
        tick        = 1'b0;
        pipe_passed = 1'b0;
        step();

        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Per-frame bird engine that produces `collision` and consumes `game_enable` and `game_reset` from the game manager FSM.
- Integrates gravity and flap impulses into the bird's vertical position, once per frame tick.
- Detects hits against the ceiling, the floor and pipe columns.
- Counts pipes passed.
- Sits between the game manager, the pipe scroller (which supplies pipe overlap, gap bounds and pass pulses) and the VGA renderer (which reads `bird_y` and `score`).

Parameters:
- Y_W, 8, width of vertical coordinate
- Y_MAX, 239, last visible row (floor)
- Y_START, 120, bird top row after reset
- BIRD_H, 8, bird height in rows
- GRAVITY, 1, velocity added per tick
- FLAP_VEL, -6, velocity loaded on flap (signed)
- V_MAX, 8, terminal downward velocity

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- game_reset, input, 1, game manager in ready state
- game_enable, input, 1, game manager in playing state
- tick, input, 1, one-cycle frame strobe
- flap, input, 1, debounced flap button level
- pipe_overlap, input, 1, a pipe column horizontally overlaps the bird
- gap_top, input, Y_W, first open row of the overlapping pipe's gap
- gap_bot, input, Y_W, last open row of the gap
- pipe_passed, input, 1, one-cycle pulse when a pipe's trailing edge clears the bird
- bird_y, output, Y_W, bird top row
- collision, output, 1, sticky hit flag
- score, output, 8, pipes passed, binary, saturating

Behaviour:
- reset: synchronous, active-high; clock clk.
- Reset values:
  - `bird_y` = Y_START
  - `vel` = 0
  - `collision` = 0
  - `score` = 0
  - flap latch = 0
  - edge-detector history = 0
  - state = IDLE
- States:
  - IDLE: `game_reset` high. Hold reset values and ignore all other inputs.
  - FLY: `game_enable` high and `collision` = 0.
  - HIT: `collision` = 1. Freeze `bird_y`, `vel` and `score`.
- Transitions:
  - IDLE -> FLY when `game_enable` = 1.
  - FLY -> HIT on a registered collision.
  - Any state -> IDLE when `game_reset` = 1. This has priority over everything except `reset`.
  - With `game_enable` = 0 and `game_reset` = 0 (manager done state), all registers hold.
- Flap capture:
  - A rising edge of `flap` is detected with a one-cycle delayed copy.
  - It sets the flap latch only while in FLY.
  - Several edges between two ticks count as one.
  - The latch clears on the tick that consumes it.
- Tick update (FLY only):
  - `vel_n` = FLAP_VEL if the latch is set or an edge is seen in the same cycle; otherwise min(`vel` + GRAVITY, V_MAX).
  - `y_n` = `bird_y` + `vel_n`, computed in signed Y_W+2 bits.
  - Both are registered on the tick cycle, so `bird_y` changes one cycle after `tick`.
  - `vel` is a signed 5-bit value, range -8..+8.
- Boundaries:
  - `y_n` < 0: `bird_y` = 0, `collision` = 1.
  - `y_n` + BIRD_H - 1 > Y_MAX: `bird_y` = Y_MAX - BIRD_H + 1, `collision` = 1.
- Pipe hit:
  - Evaluated every cycle in FLY against the registered `bird_y`.
  - Condition: `pipe_overlap` and (`bird_y` < `gap_top` or `bird_y` + BIRD_H - 1 > `gap_bot`).
  - Sets `collision` on the next edge, giving 1-cycle latency.
- Score:
  - A `pipe_passed` pulse in FLY increments `score` on the next edge.
  - `score` saturates at 255.
  - If the same cycle also raises a collision, `collision` wins and `score` does not increment.
- `collision` stays high until `game_reset` or `reset`.
- A `game_reset` asserted mid-flight restores all reset values on the next edge.

Decomposition:
- Package `flappy_pkg`:
  - state enum {IDLE, FLY, HIT}
  - Y_W, Y_MAX, BIRD_H
  - velocity typedef (signed 5-bit)
- Sub-module `rise_edge` (clk, reset, in, pulse): the one-cycle edge detector, reusable for `restart` and other buttons.

Test Plan:
1. Free fall:
   - Stimulus: IDLE -> FLY with `bird_y` = 120, no flap, 4 ticks.
   - Required: `bird_y` = 121, 123, 126, 130, each one cycle after its tick; `collision` = 0.
2. Flap impulse:
   - Stimulus: `bird_y` = 130, `vel` = 4; flap rising edge 3 cycles before a tick, then a second edge before the same tick.
   - Required: `vel` = -6, `bird_y` = 124; the latch clears; the next tick gives `vel` = -5, `bird_y` = 119.
3. Floor hit:
   - Stimulus: `bird_y` = 228, `vel` = 8, one tick.
   - Required: `bird_y` = 232, `collision` = 1; further ticks leave `bird_y` = 232.
4. Pipe hit:
   - Stimulus: `bird_y` = 100, `gap_top` = 90, `gap_bot` = 105, `pipe_overlap` = 1.
   - Required: since 107 > 105, `collision` rises exactly 1 cycle later.
   - With `gap_bot` = 110 instead, `collision` stays 0.
5. Score:
   - Stimulus: three `pipe_passed` pulses in FLY.
   - Required: `score` = 3.
   - Pulse coincident with the pipe-hit condition: `score` stays 3 and `collision` = 1.
   - Preload `score` = 255 and pulse: `score` stays 255.
6. Restart mid-operation:
   - Stimulus: from HIT, assert `game_reset` for 1 cycle.
   - Required: next cycle `bird_y` = 120, `score` = 0, `collision` = 0.
   - A flap edge while `game_reset` = 1 is not latched; the first tick after `game_enable` gives `bird_y` = 121.
